array_rw_ctrl: RTL and testbench
================================

ARRAY_RW_CTRL -- requirements
Module: array_rw_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 9: request/macro address width (512 entries).
REQ-002 The block SHALL have the parameter DATA_W, default 84: data width.
REQ-003 The block SHALL have the parameter MASK_W, default 4: write-mask lanes, each DATA_W/MASK_W = 21 bits.
REQ-004 The block SHALL have the parameter RESP_DEPTH, default 2: response buffer entries; it SHALL be at least 2.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: port clock, input, 1 bit, single clock.
REQ-006 reset, input, 1 bit: synchronous, active-high.
REQ-007 req_valid, input, 1 bit: request present.
REQ-008 req_ready, output, 1 bit: request accepted when high with req_valid.
REQ-009 req_write, input, 1 bit: 1 = masked write, 0 = read.
REQ-010 req_addr / req_mask / req_wdata, input, ADDR_W / MASK_W / DATA_W bits: request payload.
REQ-011 resp_valid, output, 1 bit: read data available.
REQ-012 resp_ready, input, 1 bit: consumer accepts resp_rdata.
REQ-013 resp_rdata, output, DATA_W bits: read data, in request order.
REQ-014 mem_en / mem_wmode / mem_addr / mem_wmask / mem_wdata, output, 1 / 1 / ADDR_W / MASK_W / DATA_W bits: drive the single-port macro RW0 port.
REQ-015 mem_rdata, input, DATA_W bits: macro read data, valid exactly one cycle after a read issue and unstable afterwards.

Function
REQ-016 The block SHALL accept a request in cycle t if req_valid && req_ready; in the same cycle mem_en=1, mem_wmode=req_write, and addr/mask/wdata SHALL be passed through combinationally.
REQ-017 mem_en SHALL be 0 in every cycle with no accepted request; mem_wmask SHALL be 0 on reads.
REQ-018 Writes SHALL produce no response, and req_ready SHALL be 1 for writes whenever reset is low.
REQ-019 For reads, req_ready SHALL be 1 iff inflight + occ < RESP_DEPTH, where inflight (0/1) = a read issued last cycle and occ = buffered entries; req_ready SHALL NOT depend combinationally on resp_ready.
REQ-020 For a read issued in cycle t, mem_rdata in cycle t+1 SHALL be returned.
REQ-021 If occ=0 in t+1: resp_valid=1 and resp_rdata=mem_rdata (bypass, 1-cycle latency).
REQ-022 If that bypassed response is not accepted, or occ>0, mem_rdata SHALL be written into the FIFO tail at the end of t+1.
REQ-023 If occ>0: resp_valid=1 and resp_rdata SHALL equal the FIFO head; a pop SHALL occur on resp_valid && resp_ready.
REQ-024 Simultaneous push and pop SHALL leave occ unchanged; the FIFO pointers SHALL wrap modulo RESP_DEPTH.
REQ-025 occ SHALL never exceed RESP_DEPTH; a push when full is impossible by REQ-019 and SHALL be flagged by a simulation assertion.
REQ-026 Write after read: a write to the same address in cycle t+1 SHALL NOT corrupt the response, which is captured or bypassed in t+1.
REQ-027 Sustained reads with resp_ready=1 SHALL achieve 1 read per cycle.

Reset
REQ-028 While reset=1: req_ready=0, resp_valid=0, mem_en=0, occ=0, inflight=0, pointers=0.
REQ-029 A read in flight when reset asserts SHALL be discarded, and no response for it SHALL appear after reset.
REQ-030 resp_rdata SHALL be don't-care while resp_valid=0.

Configuration
REQ-031 With ARRAY_CTRL_STATS_EN defined, the block SHALL add 32-bit outputs stat_reads, stat_writes (accepted requests) and stat_stalls (cycles with resp_valid && !resp_ready), each cleared by reset and wrapping at 2^32.
REQ-032 Without ARRAY_CTRL_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-033 Write addr 5, wdata all-ones, mask 4'b0101, over prior zero; then read 5 -> resp_rdata lanes 0 and 2 = 21'h1FFFFF, lanes 1 and 3 = 0, resp_valid in the cycle after issue.
REQ-034 10 back-to-back reads of addrs 0..9 with resp_ready=1 -> req_ready held 1, 10 in-order responses, 1 per cycle.
REQ-035 resp_ready=0 with reads streamed -> exactly 2 reads accepted, then req_ready=0 for reads while writes are still accepted; raising resp_ready -> both responses in order, then reads resume.
REQ-036 Read addr 7 (value A) in cycle t, write addr 7 value B in t+1, resp_ready=0 -> response = A; a later read -> B.
REQ-037 Reset asserted the cycle after a read issue -> no resp_valid in any cycle after reset deasserts; occ=0.
REQ-038 With ARRAY_CTRL_STATS_EN: 3 reads, 2 writes, 4 stall cycles -> stat_reads=3, stat_writes=2, stat_stalls=4.

Source files
------------

// File: rtl/array_rw_ctrl.sv
// -----------------------------------------------------------------------------
// array_rw_ctrl
//
// Request/response front end for a single-port (RW0) SRAM macro. Requests are
// passed straight through to the macro in the cycle they are accepted. Read
// data, which the macro only holds for the single cycle after the read, is
// either bypassed to the response port or parked in a small response FIFO.
// Read flow control guarantees that every issued read has a FIFO slot, so
// macro data is never lost, even while the consumer stalls.
//
// Parameters
//   ADDR_W      macro address width
//   DATA_W      data width
//   MASK_W      write-mask lanes (DATA_W/MASK_W bits per lane)
//   RESP_DEPTH  response FIFO entries (must be >= 2 for full read throughput)
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_write                1 = masked write, 0 = read
//   req_addr/mask/wdata      request payload
//   resp_valid / resp_ready  read-response handshake
//   resp_rdata               read data, in request order
//   mem_en/wmode/addr/wmask/wdata  macro RW0 port drive
//   mem_rdata                macro read data (valid one cycle after issue)
//
// Optional build macro
//   ARRAY_CTRL_STATS_EN  adds 32-bit wrapping counters stat_reads, stat_writes
//                        (accepted requests) and stat_stalls (cycles with
//                        resp_valid && !resp_ready).
// -----------------------------------------------------------------------------
module array_rw_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 84,
  parameter int MASK_W     = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARRAY_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OCC_W = $clog2(RESP_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(RESP_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_CNT = (OCC_W + 1)'(RESP_DEPTH);

  logic              inflight;   // a read was issued to the macro last cycle
  logic [OCC_W-1:0]  occ;        // buffered responses
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  logic fifo_empty;
  logic read_room;
  logic accept;
  logic read_issue;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    // Explicit wrap so non-power-of-two depths work.
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: every output of this block gets a value before any condition is
  // tested, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fifo_empty = (occ == '0);

    // A read may issue only if a FIFO slot is reserved for it, counting the
    // read whose data arrives this cycle. Deliberately independent of
    // resp_ready so the request side has no combinational path from the
    // response side.
    read_room  = ({1'b0, occ} + {{OCC_W{1'b0}}, inflight}) < DEPTH_CNT;
    req_ready  = !reset && (req_write || read_room);
    accept     = req_valid && req_ready;
    read_issue = accept && !req_write;

    // Buffered data is always older than the macro output, so the head wins;
    // the macro output is only presented directly when the FIFO is empty.
    resp_valid = !reset && (!fifo_empty || inflight);
    resp_rdata = fifo_empty ? mem_rdata : fifo_mem[rd_ptr];

    pop  = !fifo_empty && resp_ready && resp_valid;
    // Macro data must be captured unless it left via the bypass this cycle;
    // it is only valid now, so a later write to the same address cannot
    // disturb it.
    push = !reset && inflight && !(fifo_empty && resp_ready);

    mem_en    = accept;
    mem_wmode = req_write;
    mem_addr  = req_addr;
    mem_wmask = req_write ? req_mask : '0;
    mem_wdata = req_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;   // drops any read in flight: no response after reset
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= read_issue;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; occ and the pointers decide which
  // entries are meaningful, so resetting the data would only add logic.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // Read flow control makes a push into a full FIFO unreachable.
  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && occ == OCC_FULL));

`ifdef ARRAY_CTRL_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (read_issue)               stat_reads  <= stat_reads  + 32'd1;
      if (accept && req_write)      stat_writes <= stat_writes + 32'd1;
      if (resp_valid && !resp_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_array_rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_array_rw_ctrl
//
// Directed bench for array_rw_ctrl. A behavioural single-port macro model
// answers reads one cycle after issue and drives junk otherwise. The stimulus
// process pushes the expected read data (from its own reference memory) into
// a queue when a read is accepted; a monitor pops and compares on every
// response handshake. Directed checks cover reset, pass-through, latency,
// throughput, back-pressure, write-after-read and reset during a read.
// -----------------------------------------------------------------------------
module tb_array_rw_ctrl;

  localparam int AW = 9;
  localparam int DW = 84;
  localparam int MW = 4;
  localparam int LW = DW / MW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [MW-1:0] req_mask = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          mem_en;
  logic          mem_wmode;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARRAY_CTRL_STATS_EN
  logic [31:0]   stat_reads;
  logic [31:0]   stat_writes;
  logic [31:0]   stat_stalls;
`endif

  array_rw_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RESP_DEPTH(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_wmode  (mem_wmode),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef ARRAY_CTRL_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rst_d  = 1'b1;

  logic [DW-1:0] exp_q[$];
  int            pop_cycles[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Initial content of every address; address 5 starts at zero.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (a != AW'(5))
      for (int k = 0; k < MW; k++) v[k*LW +: LW] = LW'(int'(a) * 1000 + k * 7 + 1);
    return v;
  endfunction

  // ---------------- macro model -------------------------------------------
  logic [DW-1:0] mac_mem [1 << AW];
  bit            mac_wr  [1 << AW];
  logic [DW-1:0] mac_tmp;

  always @(posedge clock) begin
    if (mem_en && !mem_wmode)
      mem_rdata <= mac_wr[mem_addr] ? mac_mem[mem_addr] : pattern(mem_addr);
    else
      mem_rdata <= DW'({$urandom(), $urandom(), $urandom()});
    if (mem_en && mem_wmode) begin
      mac_tmp = mac_wr[mem_addr] ? mac_mem[mem_addr] : pattern(mem_addr);
      for (int k = 0; k < MW; k++)
        if (mem_wmask[k]) mac_tmp[k*LW +: LW] = mem_wdata[k*LW +: LW];
      mac_mem[mem_addr] <= mac_tmp;
      mac_wr[mem_addr]  <= 1'b1;
    end
  end

  // ---------------- reference memory --------------------------------------
  logic [DW-1:0] ref_mem [1 << AW];
  bit            ref_wr  [1 << AW];

  function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : pattern(a);
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [MW-1:0] m,
                           input logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = ref_val(a);
    for (int k = 0; k < MW; k++) if (m[k]) v[k*LW +: LW] = d[k*LW +: LW];
    ref_mem[a] = v;
    ref_wr[a]  = 1'b1;
  endtask

  // ---------------- monitor -----------------------------------------------
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      pop_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got %h with no read outstanding", resp_rdata);
      end else begin
        check("resp_rdata", 128'(resp_rdata), 128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  // One clock cycle: drive just after the rising edge, sample on the falling.
  task automatic cycle(input logic v, input logic w, input int a,
                       input logic [MW-1:0] m, input logic [DW-1:0] d,
                       input logic rr, output logic acc);
    @(posedge clock);
    #1;
    reset      = rst_d;
    req_valid  = v;
    req_write  = w;
    req_addr   = AW'(a);
    req_mask   = m;
    req_wdata  = d;
    resp_ready = rr;
    if (rst_d) exp_q.delete();
    @(negedge clock);
    acc = v && req_ready;
    if (acc) begin
      if (w) ref_write(AW'(a), m, d);
      else   exp_q.push_back(ref_val(AW'(a)));
    end
  endtask

  task automatic idle(input logic rr);
    logic acc;
    cycle(1'b0, 1'b0, 0, '0, '0, rr, acc);
  endtask

  task automatic rd(input int a, input logic rr, output logic acc);
    // Mask is driven to all-ones to show it is blanked on reads.
    cycle(1'b1, 1'b0, a, '1, '0, rr, acc);
  endtask

  task automatic wr(input int a, input logic [MW-1:0] m, input logic [DW-1:0] d,
                    input logic rr, output logic acc);
    cycle(1'b1, 1'b1, a, m, d, rr, acc);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_outstanding", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] VAL_B   = 84'h123456789ABCDEF012345;
  localparam logic [DW-1:0] EXP_033 = {21'h0, 21'h1FFFFF, 21'h0, 21'h1FFFFF};

  initial begin
    logic acc;
    int   n_acc;
    int   span;

    // ---- reset: requests offered but nothing may happen ----
    rst_d = 1'b1;
    rd(3, 1'b1, acc);
    check("rst_req_ready_rd", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_mem_en", 128'(mem_en), 128'(0));
    wr(3, '1, '1, 1'b1, acc);
    check("rst_req_ready_wr", 128'(req_ready), 128'(0));
    rst_d = 1'b0;

    // ---- masked write then read of address 5 ----
    wr(5, 4'b0101, '1, 1'b1, acc);
    check("wr5_accept", 128'(acc), 128'(1));
    check("wr5_mem_en", 128'(mem_en), 128'(1));
    check("wr5_wmode", 128'(mem_wmode), 128'(1));
    check("wr5_addr", 128'(mem_addr), 128'(5));
    check("wr5_wmask", 128'(mem_wmask), 128'(4'b0101));
    rd(5, 1'b1, acc);
    check("rd5_accept", 128'(acc), 128'(1));
    check("rd5_wmode", 128'(mem_wmode), 128'(0));
    check("rd5_wmask_zero", 128'(mem_wmask), 128'(0));
    idle(1'b1);
    check("rd5_latency_valid", 128'(resp_valid), 128'(1));
    check("rd5_data", 128'(resp_rdata), 128'(EXP_033));
    check("idle_mem_en", 128'(mem_en), 128'(0));
    drain(10);

    // ---- 10 back-to-back reads ----
    pop_cycles.delete();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      rd(i, 1'b1, acc);
      if (acc) n_acc++;
    end
    check("b2b_accepted", 128'(n_acc), 128'(10));
    drain(20);
    check("b2b_resp_count", 128'(pop_cycles.size()), 128'(10));
    span = (pop_cycles.size() > 0) ? pop_cycles[$] - pop_cycles[0] : -1;
    check("b2b_resp_span", 128'(span), 128'(9));

    // ---- back-pressure: only two reads fit ----
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd(20 + i, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("bp_reads_accepted", 128'(n_acc), 128'(2));
    check("bp_resp_valid", 128'(resp_valid), 128'(1));
    wr(30, 4'b1111, VAL_B, 1'b0, acc);
    check("bp_write_accepted", 128'(acc), 128'(1));
    rd(40, 1'b0, acc);
    check("bp_read_blocked", 128'(acc), 128'(0));
    pop_cycles.delete();
    rd(41, 1'b1, acc);
    check("bp_ready_not_comb", 128'(acc), 128'(0));
    rd(41, 1'b1, acc);
    check("bp_read_resumes", 128'(acc), 128'(1));
    drain(10);
    check("bp_resp_count", 128'(pop_cycles.size()), 128'(3));

    // ---- write after read to the same address ----
    rd(7, 1'b0, acc);
    check("war_rd_accept", 128'(acc), 128'(1));
    wr(7, 4'b1111, VAL_B, 1'b0, acc);
    check("war_wr_accept", 128'(acc), 128'(1));
    check("war_bypass_data", 128'(resp_rdata), 128'(pattern(AW'(7))));
    idle(1'b0);
    check("war_buffered_data", 128'(resp_rdata), 128'(pattern(AW'(7))));
    drain(10);
    rd(7, 1'b1, acc);
    idle(1'b1);
    check("war_new_data", 128'(resp_rdata), 128'(VAL_B));
    drain(10);

    // ---- reset the cycle after a read issue ----
    rd(9, 1'b0, acc);
    check("rstrd_accept", 128'(acc), 128'(1));
    rst_d = 1'b1;
    idle(1'b0);
    check("rstrd_valid_in_reset", 128'(resp_valid), 128'(0));
    idle(1'b0);
    rst_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("rstrd_no_resp", 128'(resp_valid), 128'(0));
    end
    n_acc = 0;
    rd(11, 1'b0, acc);
    if (acc) n_acc++;
    rd(12, 1'b0, acc);
    if (acc) n_acc++;
    check("rstrd_fifo_empty", 128'(n_acc), 128'(2));
    drain(10);

`ifdef ARRAY_CTRL_STATS_EN
    // ---- statistics: 3 reads, 2 writes, 4 stall cycles ----
    rst_d = 1'b1;
    idle(1'b1);
    rst_d = 1'b0;
    rd(1, 1'b0, acc);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    rd(2, 1'b0, acc);
    idle(1'b0);
    idle(1'b1);
    rd(3, 1'b1, acc);
    idle(1'b1);
    wr(100, 4'b0011, VAL_B, 1'b1, acc);
    wr(101, 4'b1100, VAL_B, 1'b1, acc);
    idle(1'b1);
    check("stat_reads", 128'(stat_reads), 128'(3));
    check("stat_writes", 128'(stat_writes), 128'(2));
    check("stat_stalls", 128'(stat_stalls), 128'(4));
    drain(10);
`endif

    idle(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
